// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// ALU select codes, opcodes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned ALU_SEL_W = 3;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned MUX_SEL_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = 3'b101;

    localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;

    localparam logic [MUX_SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [MUX_SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [MUX_SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [MUX_SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [MUX_SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [MUX_SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [MUX_SEL_W-1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [MUX_SEL_W-1:0] RESULT_DATA   = 2'b01;
    localparam logic [MUX_SEL_W-1:0] RESULT_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode/funct3/funct7b5, with a
// flag for encodings the core does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNCT3_W-1:0]  funct3,
    input  logic                 funct7b5,
    output logic [ALU_SEL_W-1:0] alu_sel_c,
    output logic                 unsupported_c
);

    always_comb begin
        alu_sel_c     = ALU_ADD;
        unsupported_c = 1'b0;
        if (opcode == OP_RTYPE || opcode == OP_ITYPE) begin
            case (funct3)
                // funct7b5 selects sub only for R-type; addi immediates reuse bit 30
                3'b000:  alu_sel_c = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_sel_c = ALU_SLT;
                3'b110:  alu_sel_c = ALU_OR;
                3'b111:  alu_sel_c = ALU_AND;
                default: unsupported_c = 1'b1;
            endcase
        end else if (opcode == OP_BEQ) begin
            alu_sel_c     = ALU_SUB;
            unsupported_c = (funct3 != 3'b000);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory access and writeback, driving the datapath mux selects.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNCT3_W-1:0]  funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [MUX_SEL_W-1:0] result_src,
    output logic [MUX_SEL_W-1:0] alu_src_a,
    output logic [MUX_SEL_W-1:0] alu_src_b,
    output logic                 reg_write,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 illegal_instr,
    output logic [STATE_W-1:0]   state_o
);

    state_t                 state;
    state_t                 state_next;
    logic [ALU_SEL_W-1:0]   dec_alu_sel;
    logic                   dec_unsupported;

    alu_decoder u_alu_decoder (
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .alu_sel_c     (dec_alu_sel),
        .unsupported_c (dec_unsupported)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    assign state_o = STATE_W'(state);

    // Next state and Moore outputs; only mem_ready, zero and the decoded ALU op gate outputs
    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RESULT_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        reg_write     = 1'b0;
        alu_sel       = ALU_ADD;
        illegal_instr = 1'b0;

        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RESULT_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = dec_unsupported ? S_ILLEGAL : S_EXECR;
                    OP_ITYPE:     state_next = dec_unsupported ? S_ILLEGAL : S_EXECI;
                    OP_BEQ:       state_next = dec_unsupported ? S_ILLEGAL : S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RESULT_ALUOUT;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RESULT_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RESULT_ALUOUT;
                mem_write  = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_sel    = dec_alu_sel;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_sel    = dec_alu_sel;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RESULT_ALUOUT;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_sel    = ALU_SUB;
                result_src = RESULT_ALUOUT;
                pc_write   = zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms the link value
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RESULT_ALUOUT;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_instr = 1'b1;
                state_next    = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a decode/cycle-count vector table plus
// hand-written reset, stall, branch and illegal-instruction sequences.
module tb_multicycle_ctrl;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BEQ      = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_ILLEGAL  = 4'd11;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_sel;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .alu_sel       (alu_sel),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       f7b5;
        logic [3:0] exp_state;
        logic [2:0] exp_alu;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    initial begin
        int  n;
        bit  done;

        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, ST_EXECR,   3'b000, 4}; // add
        vecs[1]  = '{7'b0110011, 3'b000, 1'b1, ST_EXECR,   3'b001, 4}; // sub
        vecs[2]  = '{7'b0010011, 3'b000, 1'b1, ST_EXECI,   3'b000, 4}; // addi, bit30 set
        vecs[3]  = '{7'b0110011, 3'b010, 1'b0, ST_EXECR,   3'b101, 4}; // slt
        vecs[4]  = '{7'b0010011, 3'b110, 1'b0, ST_EXECI,   3'b011, 4}; // ori
        vecs[5]  = '{7'b0010011, 3'b111, 1'b0, ST_EXECI,   3'b010, 4}; // andi
        vecs[6]  = '{7'b0000011, 3'b010, 1'b0, ST_MEMADR,  3'b000, 5}; // lw
        vecs[7]  = '{7'b0100011, 3'b010, 1'b0, ST_MEMADR,  3'b000, 4}; // sw
        vecs[8]  = '{7'b1100011, 3'b000, 1'b0, ST_BEQ,     3'b001, 3}; // beq
        vecs[9]  = '{7'b1101111, 3'b000, 1'b0, ST_JAL,     3'b000, 4}; // jal
        vecs[10] = '{7'b1100011, 3'b001, 1'b0, ST_ILLEGAL, 3'b000, 3}; // bne
        vecs[11] = '{7'b0110011, 3'b100, 1'b0, ST_ILLEGAL, 3'b000, 3}; // xor
        vecs[12] = '{7'b1111111, 3'b000, 1'b0, ST_ILLEGAL, 3'b000, 3};
        vecs[13] = '{7'b0110111, 3'b000, 1'b0, ST_ILLEGAL, 3'b000, 3}; // lui

        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        set_instr(7'd0, 3'd0, 1'b0);
        tick(); tick();
        check("reset_state", 32'(state_o), 32'(ST_FETCH));
        check("reset_adr_src", 32'(adr_src), 32'd0);
        check("reset_src_b", 32'(alu_src_b), 32'd2);
        check("reset_result_src", 32'(result_src), 32'd2);
        check("reset_ir_write", 32'(ir_write), 32'd1);
        check("reset_pc_write", 32'(pc_write), 32'd1);
        mem_ready = 1'b0; #1;
        check("fetch_stall_ir_write", 32'(ir_write), 32'd0);
        mem_ready = 1'b1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            set_instr(vecs[i].opcode, vecs[i].funct3, vecs[i].f7b5);
            check($sformatf("v%0d_fetch", i), 32'(state_o), 32'(ST_FETCH));
            tick();
            check($sformatf("v%0d_decode", i), 32'(state_o), 32'(ST_DECODE));
            tick();
            check($sformatf("v%0d_state", i), 32'(state_o), 32'(vecs[i].exp_state));
            check($sformatf("v%0d_alu_sel", i), 32'(alu_sel), 32'(vecs[i].exp_alu));
            n = 3; done = 1'b0;
            for (int k = 0; k < 10 && !done; k++) begin
                tick();
                if (state_o == ST_FETCH) done = 1'b1;
                else n++;
            end
            check($sformatf("v%0d_returned", i), 32'(done), 32'd1);
            check($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].exp_cycles));
        end

        // reset asserted mid-MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        check("rst_pre_memread", 32'(state_o), 32'(ST_MEMREAD));
        rst = 1'b1;
        tick();
        check("rst_to_fetch", 32'(state_o), 32'(ST_FETCH));
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        tick();
        check("rst_hold_fetch", 32'(state_o), 32'(ST_FETCH));
        mem_ready = 1'b1; #1;
        check("rst_ir_write", 32'(ir_write), 32'd1);
        rst = 1'b0;

        // sub x3,x1,x2 sequence
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick();
        check("sub_decode", 32'(state_o), 32'(ST_DECODE));
        tick();
        check("sub_execr", 32'(state_o), 32'(ST_EXECR));
        check("sub_alu_sel", 32'(alu_sel), 32'd1);
        check("sub_src_a", 32'(alu_src_a), 32'd2);
        check("sub_src_b", 32'(alu_src_b), 32'd0);
        check("sub_exec_reg_write", 32'(reg_write), 32'd0);
        tick();
        check("sub_aluwb", 32'(state_o), 32'(ST_ALUWB));
        check("sub_wb_reg_write", 32'(reg_write), 32'd1);
        check("sub_wb_result_src", 32'(result_src), 32'd0);
        tick();
        check("sub_back_fetch", 32'(state_o), 32'(ST_FETCH));
        check("sub_fetch_reg_write", 32'(reg_write), 32'd0);

        // lw with two stall cycles in MEMREAD
        set_instr(7'b0000011, 3'b010, 1'b0);
        tick(); tick();
        check("lw_memadr", 32'(state_o), 32'(ST_MEMADR));
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin
                mem_ready = 1'b1; #1;
            end
            check($sformatf("lw_memread_c%0d", c), 32'(state_o), 32'(ST_MEMREAD));
            check($sformatf("lw_adr_src_c%0d", c), 32'(adr_src), 32'd1);
            check($sformatf("lw_result_src_c%0d", c), 32'(result_src), 32'd0);
        end
        tick();
        check("lw_memwb", 32'(state_o), 32'(ST_MEMWB));
        check("lw_wb_result_src", 32'(result_src), 32'd1);
        check("lw_wb_reg_write", 32'(reg_write), 32'd1);
        check("lw_wb_mem_write", 32'(mem_write), 32'd0);
        tick();
        check("lw_back_fetch", 32'(state_o), 32'(ST_FETCH));

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            set_instr(7'b1100011, 3'b000, 1'b0);
            zero = 1'(z);
            tick(); tick();
            check($sformatf("beq_z%0d_state", z), 32'(state_o), 32'(ST_BEQ));
            check($sformatf("beq_z%0d_pc_write", z), 32'(pc_write), 32'(z));
            check($sformatf("beq_z%0d_alu_sel", z), 32'(alu_sel), 32'd1);
            tick();
            check($sformatf("beq_z%0d_fetch", z), 32'(state_o), 32'(ST_FETCH));
        end
        zero = 1'b0;

        // unknown opcode, then ori with unsupported funct3
        for (int j = 0; j < 2; j++) begin
            if (j == 0) set_instr(7'b1111111, 3'b000, 1'b0);
            else        set_instr(7'b0010011, 3'b100, 1'b0);
            tick();
            check($sformatf("ill%0d_decode_pulse", j), 32'(illegal_instr), 32'd0);
            tick();
            check($sformatf("ill%0d_state", j), 32'(state_o), 32'(ST_ILLEGAL));
            check($sformatf("ill%0d_pulse", j), 32'(illegal_instr), 32'd1);
            check($sformatf("ill%0d_strobes", j),
                  32'({pc_write, mem_write, reg_write, ir_write}), 32'd0);
            tick();
            check($sformatf("ill%0d_fetch", j), 32'(state_o), 32'(ST_FETCH));
            check($sformatf("ill%0d_pulse_end", j), 32'(illegal_instr), 32'd0);
        end

        // sw with one stall cycle in MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        check("sw_memwrite_c0", 32'(state_o), 32'(ST_MEMWRITE));
        check("sw_mem_write_c0", 32'(mem_write), 32'd1);
        check("sw_adr_src_c0", 32'(adr_src), 32'd1);
        check("sw_reg_write_c0", 32'(reg_write), 32'd0);
        tick();
        mem_ready = 1'b1; #1;
        check("sw_memwrite_c1", 32'(state_o), 32'(ST_MEMWRITE));
        check("sw_mem_write_c1", 32'(mem_write), 32'd1);
        check("sw_reg_write_c1", 32'(reg_write), 32'd0);
        tick();
        check("sw_back_fetch", 32'(state_o), 32'(ST_FETCH));
        check("sw_fetch_mem_write", 32'(mem_write), 32'd0);
        check("sw_fetch_reg_write", 32'(reg_write), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
